// File: rtl/if_id_stage_reg_if.sv
// if_id_stage_reg_if: IF->ID stage bundle; master = fetch/decode side (drives in_*, flush, out_ready), slave = stage register (drives in_ready, out_*, occupancy)
interface if_id_stage_reg_if #(
  parameter int PC_W = 64,
  parameter int INST_W = 32
);
  logic in_valid;
  logic in_ready;
  logic [PC_W-1:0] in_pc;
  logic [PC_W-1:0] in_pc_next;
  logic [INST_W-1:0] in_inst;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_pc_next;
  logic [INST_W-1:0] out_inst;
  logic out_misaligned;
  logic [1:0] occupancy;
  modport master (
    output in_valid, in_pc, in_pc_next, in_inst, flush, out_ready,
    input in_ready, out_valid, out_pc, out_pc_next, out_inst, out_misaligned, occupancy
  );
  modport slave (
    input in_valid, in_pc, in_pc_next, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_pc_next, out_inst, out_misaligned, occupancy
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: IF->ID 2-entry skid pipeline register with flush; ports clk, reset (async active-low), bus (slave: fetch in_*, decode out_*, flush, occupancy)
module if_id_stage_reg #(
  parameter int PC_W = 64,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input logic clk,
  input logic reset,
  if_id_stage_reg_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic mis;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pcn;
    logic [INST_W-1:0] inst;
  } ent_t;
  state_t state;
  ent_t head, skid, in_e;
  logic rdy, acc, pop, v;
  assign in_e = '{mis: bus.in_pc[1:0] != 2'b00, pc: bus.in_pc, pcn: bus.in_pc_next, inst: bus.in_inst};
  assign v = state != EMPTY;
  assign acc = bus.in_valid && rdy;
  assign pop = v && bus.out_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= EMPTY;
      rdy <= 1'b1;
      head <= '0;
      skid <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
      rdy <= 1'b1;
    end else
      case (state)
        EMPTY: if (acc) begin
          head <= in_e;
          state <= ONE;
        end
        ONE: if (acc && pop) head <= in_e;
        else if (acc) begin
          skid <= in_e;
          state <= FULL;
          rdy <= 1'b0;
        end else if (pop) state <= EMPTY;
        FULL: if (pop) begin
          head <= skid;
          state <= ONE;
          rdy <= 1'b1;
        end
        default: begin
          state <= EMPTY;
          rdy <= 1'b1;
        end
      endcase
  assign bus.in_ready = rdy;
  assign bus.out_valid = v;
  assign bus.out_pc = v ? head.pc : '0;
  assign bus.out_pc_next = v ? head.pcn : '0;
  assign bus.out_inst = v ? head.inst : NOP_INST;
  assign bus.out_misaligned = v && head.mis;
  assign bus.occupancy = state;
endmodule

// File: tb/tb_if_id_stage_reg.sv
// tb_if_id_stage_reg: randomized + directed bench for if_id_stage_reg against a queue-based FIFO model
module tb_if_id_stage_reg;
  typedef struct {
    logic [63:0] pc;
    logic [63:0] pcn;
    logic [31:0] inst;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  ent_t q[$];
  logic m_rdy = 1'b1;
  if_id_stage_reg_if bus ();
  if_id_stage_reg dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_rdy = 1'b1;
    end else begin
      bit acc, pop;
      acc = bus.in_valid && m_rdy;
      pop = q.size() != 0 && bus.out_ready;
      if (bus.flush) q.delete();
      else begin
        if (pop) q.delete(0);
        if (acc) q.push_back('{pc: bus.in_pc, pcn: bus.in_pc_next, inst: bus.in_inst});
      end
      m_rdy = q.size() < 2;
    end
  end
  always @(negedge clk) if (reset) begin
    bit v;
    v = q.size() != 0;
    chk("model_out_valid", 64'(bus.out_valid), 64'(v));
    chk("model_occupancy", 64'(bus.occupancy), 64'(q.size()));
    chk("model_in_ready", 64'(bus.in_ready), 64'(m_rdy));
    chk("model_out_pc", bus.out_pc, v ? q[0].pc : 64'd0);
    chk("model_out_pc_next", bus.out_pc_next, v ? q[0].pcn : 64'd0);
    chk("model_out_inst", 64'(bus.out_inst), v ? 64'(q[0].inst) : 64'h13);
    chk("model_out_misaligned", 64'(bus.out_misaligned), 64'(v && q[0].pc[1:0] != 2'b00));
  end
  task automatic drive(bit iv, logic [63:0] pc, logic [31:0] inst, bit ordy, bit fl);
    bus.in_valid = iv;
    bus.in_pc = pc;
    bus.in_pc_next = pc + 64'd4;
    bus.in_inst = inst;
    bus.out_ready = ordy;
    bus.flush = fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [63:0] rpc;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_pc_next = '0;
    bus.in_inst = '0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_inst", 64'(bus.out_inst), 64'h13);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    drive(1, 64'h0, 32'h00500093, 1, 0);
    chk("stream0_pc", bus.out_pc, 64'h0);
    chk("stream0_inst", 64'(bus.out_inst), 64'h00500093);
    drive(1, 64'h4, 32'h00a00113, 1, 0);
    chk("stream1_pc", bus.out_pc, 64'h4);
    chk("stream1_pcn", bus.out_pc_next, 64'h8);
    drive(1, 64'h8, 32'h002081b3, 1, 0);
    chk("stream2_pc", bus.out_pc, 64'h8);
    chk("stream2_inst", 64'(bus.out_inst), 64'h002081b3);
    chk("stream2_occ", 64'(bus.occupancy), 64'd1);
    drive(0, 64'h0, 32'h0, 1, 0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    drive(1, 64'h10, 32'h11, 0, 0);
    drive(1, 64'h14, 32'h22, 0, 0);
    chk("bp_occ", 64'(bus.occupancy), 64'd2);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1, 64'h18, 32'h33, 0, 0);
    chk("bp_hold_occ", 64'(bus.occupancy), 64'd2);
    chk("bp_head0", bus.out_pc, 64'h10);
    drive(1, 64'h18, 32'h33, 1, 0);
    chk("bp_head1", bus.out_pc, 64'h14);
    drive(1, 64'h18, 32'h33, 1, 0);
    chk("bp_head2", bus.out_pc, 64'h18);
    drive(0, 64'h0, 32'h0, 1, 0);
    chk("bp_drained", 64'(bus.out_valid), 64'd0);
    drive(1, 64'h20, 32'h44, 0, 0);
    drive(1, 64'h24, 32'h55, 0, 0);
    drive(1, 64'h28, 32'h66, 0, 1);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_occ", 64'(bus.occupancy), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_pc_zero", bus.out_pc, 64'd0);
    drive(1, 64'h100, 32'h77, 0, 0);
    chk("post_flush_pc", bus.out_pc, 64'h100);
    drive(0, 64'h0, 32'h0, 1, 0);
    chk("post_flush_empty", 64'(bus.occupancy), 64'd0);
    drive(1, 64'h2, 32'h88, 0, 0);
    chk("misaligned", 64'(bus.out_misaligned), 64'd1);
    drive(1, 64'h6, 32'h99, 0, 0);
    chk("pre_reset_occ", 64'(bus.occupancy), 64'd2);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_occ", 64'(bus.occupancy), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("async_rst_inst", 64'(bus.out_inst), 64'h13);
    chk("async_rst_pc", bus.out_pc, 64'd0);
    chk("async_rst_mis", 64'(bus.out_misaligned), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      drive($urandom_range(0, 3) != 0, rpc, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    drive(0, 64'h0, 32'h0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- Pipeline register between the instruction-fetch stage and decode in the 64-bit RISC-V datapath.
- Captures {pc, pc_next, instruction} from fetch with a valid/ready handshake and presents them to decode one cycle later.
- 2-entry skid buffer: decode back-pressure never drops or duplicates an instruction, and no combinational path runs from out_ready to in_ready.
- Synchronous flush discards all in-flight fetches on a branch or jump redirect.

Parameters:
- PC_W, 64, width of pc and pc_next.
- INST_W, 32, instruction width.
- NOP_INST, 32'h00000013, value driven on out_inst when out_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  fetch presents a valid entry.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  PC_W  pc of fetched instruction.
- in_pc_next  in  PC_W  sequential next pc from fetch.
- in_inst  in  INST_W  fetched instruction word.
- flush  in  1  discard all held entries this cycle.
- out_valid  out  1  entry available to decode.
- out_ready  in  1  decode accepts the entry.
- out_pc  out  PC_W  pc of head entry.
- out_pc_next  out  PC_W  pc_next of head entry.
- out_inst  out  INST_W  head instruction; NOP_INST when out_valid=0.
- out_misaligned  out  1  head entry pc[1:0] != 0.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Transfers:
  - Accept when in_valid and in_ready at a rising edge.
  - Pop when out_valid and out_ready at a rising edge.
- Storage: head register (drives outputs) and skid register. FSM states EMPTY (0), ONE (1), FULL (2); occupancy equals the state encoding.
- Transitions (flush=0):
  - EMPTY + accept -> ONE; entry goes to head.
  - ONE + accept only -> FULL; entry goes to skid.
  - ONE + pop only -> EMPTY.
  - ONE + accept + pop -> ONE; head <= new entry.
  - FULL + pop -> ONE; head <= skid. in_ready=0 in FULL, so no accept occurs.
  - No event -> state and registers hold.
- in_ready is registered: it is 1 in the cycle after the FSM enters EMPTY or ONE, and 0 in the cycle after it enters FULL.
- Timing:
  - Latency is 1 cycle: an entry accepted at edge N appears at out_* after edge N.
  - Throughput is 1 entry/cycle while out_ready=1.
  - out_* and out_valid are driven only from registers; there is no combinational in->out path.
- Ordering is strict FIFO. Entries are never dropped or duplicated.
- Flush:
  - At an edge with flush=1, the next state is EMPTY, out_valid=0, in_ready=1.
  - A simultaneous accept is discarded.
  - A simultaneous pop still counts as consumed by decode; the entry is not replayed.
  - Flush takes priority over every other event.
- Outputs when out_valid=0: out_inst=NOP_INST, out_pc=0, out_pc_next=0, out_misaligned=0.
- out_misaligned is computed from in_pc[1:0] at capture and stored with the entry. It is a flag only; the stage takes no action on it.
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - State EMPTY, out_valid=0, occupancy=0, in_ready=1.
  - out_inst=NOP_INST, out_pc=0, out_pc_next=0, out_misaligned=0.
  - Skid contents cleared.
- Reset deassertion is synchronised externally. The first accept can occur at the first edge after reset=1.
- Inputs are ignored when in_valid=0. out_ready is ignored when out_valid=0.

Test Plan:
- Reset then idle: reset=0 for 3 cycles then 1 -> out_valid=0, out_inst=32'h00000013, in_ready=1, occupancy=0.
- Streaming: out_ready=1; push pc=0,4,8 with inst 32'h00500093, 32'h00a00113, 32'h002081b3 on consecutive cycles -> the same triples appear on out_* one cycle later each, out_pc_next=pc+4, occupancy stays 1.
- Back-pressure: out_ready=0; push pc=0x10, 0x14 -> occupancy=2 and in_ready=0 the next cycle. A third in_valid (pc 0x18) is held by fetch and not accepted. Raise out_ready -> out_pc sequence 0x10, 0x14, 0x18 with no loss or duplication.
- Flush: in FULL (pc 0x20, 0x24), assert flush together with in_valid (pc 0x28) -> next cycle out_valid=0, occupancy=0, in_ready=1. Push pc 0x100 -> out_pc=0x100, and 0x20/0x24/0x28 never appear.
- Misaligned and reset mid-operation: push pc=0x2 -> out_misaligned=1. With occupancy=2, pull reset low between clock edges -> outputs go to reset values immediately, without waiting for a clk edge.
